// File: rtl/bus_arb_pkg.sv
// Shared constants for the two-master memory bus arbiter: FSM encoding,
// one-hot grant codes and the default error read data.
package bus_arb_pkg;

  typedef logic [1:0] grant_t;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam grant_t GNT_NONE = 2'b00;
  localparam grant_t GNT_M0   = 2'b01;
  localparam grant_t GNT_M1   = 2'b10;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that did not own the bus last.
module rr_pick2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] winner
);

  // Winner decode; last_owner=1 means m1 owned the bus last
  always_comb begin
    winner = GNT_NONE;
    case (req)
      2'b01:   winner = GNT_M0;
      2'b10:   winner = GNT_M1;
      2'b11:   winner = last_owner ? GNT_M0 : GNT_M1;
      default: winner = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between CPU (m0) and a second master (m1) on the native
// valid/ready memory bus, with a watchdog that force-completes hung accesses.
module mem_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  input  logic        timeout_clr
);

  // A zero TIMEOUT_CYCLES still needs a 1-bit counter to keep widths legal
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic          r_state;
  logic [1:0]    r_grant;
  logic          r_last_owner;
  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;

  logic [1:0]  w_pick;
  logic        w_busy;
  logic        w_timeout;
  logic        w_done;
  logic [31:0] w_rdata;

  rr_pick2 u_pick (
    .req        ({m1_valid, m0_valid}),
    .last_owner (r_last_owner),
    .winner     (w_pick)
  );

  assign w_busy    = (r_state == ST_BUSY);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_busy && !s_ready && (r_cnt == CNT_LAST);
  assign w_done    = w_busy && (s_ready || w_timeout);
  assign w_rdata   = s_ready ? s_rdata : ERR_RDATA;

  assign m0_ready    = w_done && r_grant[0];
  assign m1_ready    = w_done && r_grant[1];
  assign m0_rdata    = m0_ready ? w_rdata : 32'h0000_0000;
  assign m1_rdata    = m1_ready ? w_rdata : 32'h0000_0000;
  assign s_valid     = w_busy;
  assign grant       = r_grant;
  assign timeout_err = r_timeout_err;

  // Slave-side request mux; r_grant is GNT_NONE while idle so outputs read 0
  always_comb begin
    s_addr  = 32'h0000_0000;
    s_wdata = 32'h0000_0000;
    s_wstrb = 4'h0;
    case (r_grant)
      GNT_M0: begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
      end
      GNT_M1: begin
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
      end
      default: begin
        s_addr  = 32'h0000_0000;
        s_wdata = 32'h0000_0000;
        s_wstrb = 4'h0;
      end
    endcase
  end

  // Arbitration FSM, ownership history and watchdog counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= GNT_NONE;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (m0_valid || m1_valid) begin
            r_state <= ST_BUSY;
            r_grant <= w_pick;
          end
        end
        ST_BUSY: begin
          if (w_done) begin
            r_state      <= ST_IDLE;
            r_grant      <= GNT_NONE;
            r_last_owner <= r_grant[1];
            r_cnt        <= '0;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= GNT_NONE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Sticky watchdog flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end else if (timeout_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a 4-cycle watchdog.
module tb_mem_bus_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;
  logic        timeout_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err), .timeout_clr(timeout_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // One transaction from IDLE: slave acks in the first BUSY cycle.
  // keep=1 re-raises both valids so contention persists.
  task automatic serve(input logic [1:0] exp_g, input logic [31:0] rd, input bit keep);
    step();
    chk("serve_grant", {30'd0, grant}, {30'd0, exp_g});
    chk("serve_svalid", {31'd0, s_valid}, 32'd1);
    chk("serve_saddr", s_addr, exp_g[0] ? m0_addr : m1_addr);
    if (keep) begin
      m0_valid = 1'b1;
      m1_valid = 1'b1;
    end
    s_ready = 1'b1;
    s_rdata = rd;
    #1;
    chk("serve_m0_ready", {31'd0, m0_ready}, {31'd0, exp_g[0]});
    chk("serve_m1_ready", {31'd0, m1_ready}, {31'd0, exp_g[1]});
    chk("serve_m0_rdata", m0_rdata, exp_g[0] ? rd : 32'h0);
    chk("serve_m1_rdata", m1_rdata, exp_g[1] ? rd : 32'h0);
    step();
    s_ready = 1'b0;
    s_rdata = 32'h0;
    if (exp_g[0]) m0_valid = 1'b0;
    else          m1_valid = 1'b0;
    #1;
    chk("serve_idle_grant", {30'd0, grant}, 32'd0);
    chk("serve_idle_svalid", {31'd0, s_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    m0_valid = 1'b0; m1_valid = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
    m0_wstrb = 4'h0; m1_wstrb = 4'h0;
    s_ready = 1'b0; s_rdata = 32'h0; timeout_clr = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_svalid", {31'd0, s_valid}, 32'd0);
    chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_saddr", s_addr, 32'h0);

    // Single-master write, slave acks one cycle after s_valid
    m0_valid = 1'b1; m0_addr = 32'h0002_0004; m0_wdata = 32'h1234_5678; m0_wstrb = 4'hF;
    #1;
    chk("t1_c0_grant", {30'd0, grant}, 32'd0);
    step();
    chk("t1_c1_svalid", {31'd0, s_valid}, 32'd1);
    chk("t1_c1_grant", {30'd0, grant}, 32'd1);
    chk("t1_c1_saddr", s_addr, 32'h0002_0004);
    chk("t1_c1_swdata", s_wdata, 32'h1234_5678);
    chk("t1_c1_swstrb", {28'd0, s_wstrb}, 32'hF);
    chk("t1_c1_ready", {31'd0, m0_ready}, 32'd0);
    step();
    s_ready = 1'b1;
    #1;
    chk("t1_c2_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("t1_c2_m1_ready", {31'd0, m1_ready}, 32'd0);
    step();
    s_ready = 1'b0; m0_valid = 1'b0;
    #1;
    chk("t1_c3_grant", {30'd0, grant}, 32'd0);
    chk("t1_c3_ready", {31'd0, m0_ready}, 32'd0);

    // Tie after reset: m0 then m1; after a lone m0 access, a tie goes to m1
    m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000; m1_wstrb = 4'h3;
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b1;
    serve(2'b01, 32'hAAAA_0001, 1'b0);
    serve(2'b10, 32'hAAAA_0002, 1'b0);
    m0_valid = 1'b1;
    serve(2'b01, 32'hAAAA_0003, 1'b0);
    m0_valid = 1'b1; m1_valid = 1'b1;
    serve(2'b10, 32'hAAAA_0004, 1'b0);
    serve(2'b01, 32'hAAAA_0005, 1'b0);

    // Sustained contention: strict alternation starting with m0
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve((i % 2 == 0) ? 2'b01 : 2'b10, 32'hB000_0000 + 32'(i), 1'b1);
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    step();

    // Watchdog: m1 read never acknowledged; clear on the timeout cycle loses
    m1_valid = 1'b1; m1_wstrb = 4'h0; m1_addr = 32'h0000_3000;
    step();
    chk("wd_c1_grant", {30'd0, grant}, 32'd2);
    chk("wd_c1_ready", {31'd0, m1_ready}, 32'd0);
    step();
    step();
    chk("wd_c3_ready", {31'd0, m1_ready}, 32'd0);
    step();
    timeout_clr = 1'b1;
    #1;
    chk("wd_c4_m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("wd_c4_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    chk("wd_c4_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("wd_c4_err_pre", {31'd0, timeout_err}, 32'd0);
    step();
    timeout_clr = 1'b0; m1_valid = 1'b0;
    #1;
    chk("wd_err_set", {31'd0, timeout_err}, 32'd1);
    chk("wd_idle_ready", {31'd0, m1_ready}, 32'd0);
    step();
    step();
    chk("wd_err_hold", {31'd0, timeout_err}, 32'd1);
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    chk("wd_err_clr", {31'd0, timeout_err}, 32'd0);

    // s_ready exactly on the timeout cycle is a normal completion
    m0_valid = 1'b1; m0_wstrb = 4'h0;
    step();
    step();
    step();
    step();
    s_ready = 1'b1; s_rdata = 32'h55AA_33CC;
    #1;
    chk("edge_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("edge_m0_rdata", m0_rdata, 32'h55AA_33CC);
    step();
    s_ready = 1'b0; s_rdata = 32'h0; m0_valid = 1'b0;
    #1;
    chk("edge_err", {31'd0, timeout_err}, 32'd0);

    // Reset while BUSY abandons the access without a ready pulse
    m1_valid = 1'b1; m1_wstrb = 4'hF; m1_wdata = 32'h0BAD_F00D;
    step();
    chk("rb_busy_svalid", {31'd0, s_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rb_rst_cycle_ready", {31'd0, m1_ready}, 32'd0);
    step();
    chk("rb_svalid", {31'd0, s_valid}, 32'd0);
    chk("rb_grant", {30'd0, grant}, 32'd0);
    chk("rb_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("rb_saddr", s_addr, 32'h0);
    chk("rb_swdata", s_wdata, 32'h0);
    chk("rb_err", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0; m1_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
